input_checker: RTL and testbench

INPUT_CHECKER -- requirements
Module: input_checker

---
 rtl/input_checker.sv | 181 ++++++++++++++++++
 tb/tb_input_checker.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/input_checker.sv
// input_checker: grades four synchronised player keys, collected over a fixed sampling window, against the hit-row lane mask.
// Optional per-lane key debounce is compiled in with `define INPUT_DEBOUNCE_EN.
module input_checker #(
  parameter int WINDOW_CYCLES   = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       check_input_go,
  input  logic [3:0] key_n,
  input  logic [3:0] lane_mask,
  output logic       check_input_done,
  output logic       correct,
  output logic       incorrect,
  output logic [7:0] score
);

  typedef enum logic [1:0] {IDLE, WINDOW, DECIDE, HOLD} state_t;

  localparam logic [7:0] WIN_LAST = 8'(WINDOW_CYCLES - 1);

  if (WINDOW_CYCLES < 4 || WINDOW_CYCLES > 255 ||
      DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_param_check
    $error("input_checker: WINDOW_CYCLES or DEBOUNCE_CYCLES out of range");
  end

  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] key_acc;
  logic [3:0] key_acc_q;
  logic [3:0] press_evt;
  logic [3:0] press_latch;
  logic [7:0] win_cnt;
  logic       armed;
  logic       verdict_ok;
  logic       verdict_bad;
  logic       correct_n;
  logic       incorrect_n;

  state_t state;
  state_t next_state;

  logic start;
  logic win_last;
  logic clr_window;
  logic cnt_en;
  logic acc_en;
  logic decide_en;
  logic hold_out;

  // Released keys read as 1, so reset loads the synchroniser as released.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

`ifdef INPUT_DEBOUNCE_EN
  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [3:0] deb_level;
  logic [7:0] deb_cnt [4];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      deb_level <= '1;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != deb_level[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb_level[i] <= sync2[i];
            deb_cnt[i]   <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 8'd1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign key_acc = deb_level;
`else
  assign key_acc = sync2;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) key_acc_q <= '1;
    else         key_acc_q <= key_acc;
  end

  // One-cycle pulse on the accepted level's falling edge only.
  assign press_evt = key_acc_q & ~key_acc;

  assign start    = check_input_go & armed;
  assign win_last = (win_cnt == WIN_LAST);

  assign incorrect_n = ((press_latch & ~lane_mask) != 4'd0);
  assign correct_n   = (press_latch != 4'd0) & ~incorrect_n;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = WINDOW;
      WINDOW: begin
        if (!check_input_go) next_state = IDLE;
        else if (win_last)   next_state = DECIDE;
      end
      DECIDE:  next_state = check_input_go ? HOLD : IDLE;
      HOLD:    if (!check_input_go) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The last window edge is the DECIDE transition, so presses there are dropped.
  always_comb begin
    clr_window = 1'b0;
    cnt_en     = 1'b0;
    acc_en     = 1'b0;
    decide_en  = 1'b0;
    hold_out   = 1'b0;
    case (state)
      IDLE:   clr_window = start;
      WINDOW: begin
        cnt_en = check_input_go;
        acc_en = check_input_go & ~win_last;
      end
      DECIDE: decide_en = check_input_go;
      HOLD:   hold_out  = check_input_go;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      press_latch      <= '0;
      win_cnt          <= '0;
      verdict_ok       <= 1'b0;
      verdict_bad      <= 1'b0;
      score            <= '0;
      check_input_done <= 1'b0;
      correct          <= 1'b0;
      incorrect        <= 1'b0;
      armed            <= 1'b1;
    end else begin
      if (clr_window) begin
        press_latch <= '0;
        win_cnt     <= '0;
      end else begin
        if (cnt_en) win_cnt     <= win_cnt + 8'd1;
        if (acc_en) press_latch <= press_latch | press_evt;
      end

      if (decide_en) begin
        verdict_ok  <= correct_n;
        verdict_bad <= incorrect_n;
        if (correct_n && score != 8'hff) score <= score + 8'd1;
      end

      check_input_done <= hold_out;
      correct          <= hold_out & verdict_ok;
      incorrect        <= hold_out & verdict_bad;

      // A new check needs go to have been seen low since the last one started.
      if (!check_input_go) armed <= 1'b1;
      else if (start)      armed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_checker.sv
// Bench for input_checker: directed scenarios with literal expectations plus randomized checks against a check-level model.
module tb_input_checker;

  localparam int W = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       go = 1'b0;
  logic [3:0] key_n = 4'hf;
  logic [3:0] lane_mask = 4'h0;
  logic       done;
  logic       correct;
  logic       incorrect;
  logic [7:0] score;

  int n_chk = 0;
  int n_fail = 0;

  input_checker #(.WINDOW_CYCLES(W), .DEBOUNCE_CYCLES(4)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .check_input_go   (go),
    .key_n            (key_n),
    .lane_mask        (lane_mask),
    .check_input_done (done),
    .correct          (correct),
    .incorrect        (incorrect),
    .score            (score)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Check-level model: key presses seen 2 cycles late, window phases 1..W-1 count,
  // verdict at phase W+1, done from phase W+2 while go stays high.
  bit         model_en = 1'b0;
  bit         m_active = 1'b0;
  bit         m_armed = 1'b1;
  bit         m_vc = 1'b0;
  bit         m_vi = 1'b0;
  bit         started;
  int         m_phase = 0;
  int         m_score = 0;
  logic [3:0] m_press = 4'h0;
  logic [3:0] h1 = 4'hf, h2 = 4'hf, h3 = 4'hf;
  logic [3:0] ev;
  bit         e_done = 1'b0, e_cor = 1'b0, e_inc = 1'b0;

  always @(posedge clk) begin
    ev = h3 & ~h2;
    started = 1'b0;
    if (!resetn) begin
      model_en = 1'b1;
      m_active = 1'b0;
      m_armed  = 1'b1;
      m_score  = 0;
      h1 = 4'hf; h2 = 4'hf; h3 = 4'hf;
    end else begin
      h3 = h2; h2 = h1; h1 = key_n;
      if (!m_active) begin
        if (go && m_armed) begin
          m_active = 1'b1;
          m_phase  = 0;
          m_press  = 4'h0;
          started  = 1'b1;
        end
      end else if (!go) begin
        m_active = 1'b0;
      end else begin
        m_phase++;
        if (m_phase <= W - 1) m_press |= ev;
        if (m_phase == W + 1) begin
          m_vi = ((m_press & ~lane_mask) != 4'h0);
          m_vc = (m_press != 4'h0) && !m_vi;
          if (m_vc && m_score < 255) m_score++;
        end
      end
      if (!go) m_armed = 1'b1;
      else if (started) m_armed = 1'b0;
    end
    e_done = m_active && (m_phase >= W + 2);
    e_cor  = e_done && m_vc;
    e_inc  = e_done && m_vi;
  end

  always @(negedge clk) begin
    if (model_en) begin
      check("model_done", done, e_done);
      check("model_correct", correct, e_cor);
      check("model_incorrect", incorrect, e_inc);
      check("model_score", score, m_score);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One full check; key 'lane' is held low after edges p_start .. p_start+p_len-1.
  task automatic run_check(input string tag, input logic [3:0] mask, input int lane,
                           input int p_start, input int p_len,
                           input bit ec, input bit ei, input int es);
    lane_mask = mask;
    go = 1'b1;
    step(1);
    for (int c = 1; c <= W + 2; c++) begin
      key_n = 4'hf;
      if (lane >= 0 && (c - 1) >= p_start && (c - 1) < p_start + p_len) key_n[lane] = 1'b0;
      step(1);
      if (c == W + 1) check({tag, "_done_early"}, done, 0);
    end
    key_n = 4'hf;
    check({tag, "_done"}, done, 1);
    check({tag, "_correct"}, correct, ec);
    check({tag, "_incorrect"}, incorrect, ei);
    check({tag, "_score"}, score, es);
    go = 1'b0;
    step(1);
    check({tag, "_done_clear"}, done, 0);
    check({tag, "_verdict_clear"}, {correct, incorrect}, 0);
  endtask

  initial begin
    int len;
    int drop;

    step(2);
    resetn = 1'b1;
    check("reset_done", done, 0);
    check("reset_verdicts", {correct, incorrect}, 0);
    check("reset_score", score, 0);

    run_check("hit_lane2", 4'b0100, 2, 2, 10, 1'b1, 1'b0, 1);
    run_check("miss_lane0", 4'b0100, 0, 3, 3, 1'b0, 1'b1, 1);
    run_check("no_press", 4'b0010, -1, 0, 0, 1'b0, 1'b0, 1);
    run_check("glitch_lane1", 4'b0010, 1, 5, 2, 1'b1, 1'b0, 2);
    run_check("last_window", 4'b0100, 2, 12, 5, 1'b1, 1'b0, 3);
    run_check("after_window", 4'b0100, 2, 13, 5, 1'b0, 1'b0, 3);

    // Abort mid-window with a key held down.
    lane_mask = 4'b0100;
    go = 1'b1;
    step(1);
    key_n[2] = 1'b0;
    step(5);
    go = 1'b0;
    step(1);
    key_n = 4'hf;
    step(25);
    check("abort_done", done, 0);
    check("abort_score", score, 3);
    run_check("post_abort", 4'b0100, -1, 0, 0, 1'b0, 1'b0, 3);

    for (int t = 0; t < 150; t++) begin
      lane_mask = 4'($urandom);
      go = 1'b1;
      len = W + 2 + $urandom_range(0, 4);
      drop = ($urandom_range(0, 5) == 0) ? $urandom_range(0, W + 1) : -1;
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 4) == 0) key_n = key_n ^ (4'b0001 << $urandom_range(0, 3));
        if (c == drop) go = 1'b0;
        resetn = ($urandom_range(0, 199) != 0);
        step(1);
      end
      go = 1'b0;
      resetn = 1'b1;
      step($urandom_range(1, 3));
    end

    // Saturation from a clean start.
    key_n = 4'hf;
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    check("sat_reset_score", score, 0);
    for (int i = 0; i < 256; i++)
      run_check("sat", 4'b0001, 0, 2, 2, 1'b1, 1'b0, (i + 1 > 255) ? 255 : i + 1);
    check("sat_hold_255", score, 255);

    // Reset during a window discards the check.
    lane_mask = 4'b0001;
    go = 1'b1;
    step(1);
    key_n[0] = 1'b0;
    step(5);
    resetn = 1'b0;
    go = 1'b0;
    key_n = 4'hf;
    step(1);
    resetn = 1'b1;
    check("midreset_score", score, 0);
    step(30);
    check("midreset_done", done, 0);
    run_check("first_after_reset", 4'b0001, 0, 2, 2, 1'b1, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
